// File: rtl/decode_queue_stage_pkg.sv
// Shared encodings for the decode queue stage: MIPS opcode/funct/rt/rs
// values, class-vector bit positions and a small class helper.
package decode_queue_stage_pkg;

    // Class vector layout: {cp0, mdu, jump, store, load, branch, alu_i, alu_r}
    localparam int CLS_W      = 8;
    localparam int CLS_ALU_R  = 0;
    localparam int CLS_ALU_I  = 1;
    localparam int CLS_BRANCH = 2;
    localparam int CLS_LOAD   = 3;
    localparam int CLS_STORE  = 4;
    localparam int CLS_JUMP   = 5;
    localparam int CLS_MDU    = 6;
    localparam int CLS_CP0    = 7;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
        OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
        OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
        OP_COP0    = 6'h10,
        OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
        OP_LHU     = 6'h25,
        OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09,
        FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
        FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
        FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23,
        FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
        FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B
    } funct_e;

    typedef enum logic [4:0] {
        RT_BLTZ = 5'h00,
        RT_BGEZ = 5'h01
    } regimm_rt_e;

    typedef enum logic [4:0] {
        RS_MF = 5'h00,
        RS_MT = 5'h04,
        RS_CO = 5'h10
    } cop0_rs_e;

    // An instruction that redirects control leaves the next one in a delay slot.
    function automatic logic is_ctrl(input logic [CLS_W-1:0] cls);
        return cls[CLS_BRANCH] | cls[CLS_JUMP];
    endfunction

endpackage

// File: rtl/decode_queue_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue stage.
// The stage itself uses the slave view; its environment uses the master view.
interface decode_queue_stage_if
    import decode_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [CLS_W-1:0] out_cls;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [4:0]       out_shamt;
    logic [15:0]      out_imm;
    logic [25:0]      out_tgt;
    logic             out_ri;
    logic             out_ds;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_cls, out_rs, out_rt, out_rd,
               out_shamt, out_imm, out_tgt, out_ri, out_ds, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_cls, out_rs, out_rt, out_rd,
               out_shamt, out_imm, out_tgt, out_ri, out_ds, count
    );

endinterface

// File: rtl/decode_queue_stage_instr_class_dec.sv
// Combinational MIPS instruction classifier: instr -> {cls, ri}.
// Build option DEC_MDU_EN: when defined, multiply/divide and HI/LO moves
// classify as mdu; otherwise they are reserved and cls[CLS_MDU] stays 0.
module instr_class_dec
    import decode_queue_stage_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [CLS_W-1:0] cls,
    output logic             ri
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[15:6];

    // Classify the word; every unrecognised encoding lands on ri with cls=0.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        cls = '0;
        ri  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        cls[CLS_ALU_R] = 1'b1;
                    FN_JR, FN_JALR:
                        cls[CLS_JUMP] = 1'b1;
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
`ifdef DEC_MDU_EN
                        cls[CLS_MDU] = 1'b1;
`else
                        ri = 1'b1;
`endif
                    default:
                        ri = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) cls[CLS_BRANCH] = 1'b1;
                else                                ri = 1'b1;
            end
            OP_J, OP_JAL:
                cls[CLS_JUMP] = 1'b1;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                cls[CLS_BRANCH] = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                cls[CLS_ALU_I] = 1'b1;
            OP_COP0: begin
                if (rs == RS_MF || rs == RS_MT || rs == RS_CO) cls[CLS_CP0] = 1'b1;
                else                                           ri = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                cls[CLS_LOAD] = 1'b1;
            OP_SB, OP_SH, OP_SW:
                cls[CLS_STORE] = 1'b1;
            default:
                ri = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode queue stage: DEPTH-entry {pc, instr} FIFO from fetch, a decoded
// output register for execute, and delay-slot tracking across loaded entries.
// Flush discards queued and held entries. DEPTH must be a power of two >= 2
// so the pointers wrap naturally. Optional build macro: DEC_MDU_EN (see
// instr_class_dec).
module decode_queue_stage
    import decode_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    decode_queue_stage_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [CLS_W-1:0] cls;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [15:0]      imm;
        logic [25:0]      tgt;
        logic             ri;
        logic             ds;
    } out_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    out_t             out_q;
    logic             ds_flag;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           head;
    logic [CLS_W-1:0] head_cls;
    logic             head_ri;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // A full queue never accepts, even when the head leaves in the same cycle.
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && (!out_valid_q || bus.out_ready);
    assign head  = mem[rd_ptr];

    instr_class_dec u_dec (
        .instr (head.instr),
        .cls   (head_cls),
        .ri    (head_ri)
    );

    // Entry storage; a flushed cycle's push is dropped.
    // NOTE: the storage array has no reset; count and pointers mark validity.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end

    // Queue control, output register and delay-slot flag; flush beats push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ds_flag     <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ds_flag     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                out_valid_q <= 1'b1;
                out_q.pc    <= head.pc;
                out_q.cls   <= head_cls;
                out_q.ri    <= head_ri;
                out_q.rs    <= head.instr[25:21];
                out_q.rt    <= head.instr[20:16];
                out_q.rd    <= head.instr[15:11];
                out_q.shamt <= head.instr[10:6];
                out_q.imm   <= head.instr[15:0];
                out_q.tgt   <= head.instr[25:0];
                out_q.ds    <= ds_flag;
                ds_flag     <= is_ctrl(head_cls);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.count     = count_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_cls   = out_q.cls;
    assign bus.out_rs    = out_q.rs;
    assign bus.out_rt    = out_q.rt;
    assign bus.out_rd    = out_q.rd;
    assign bus.out_shamt = out_q.shamt;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_tgt   = out_q.tgt;
    assign bus.out_ri    = out_q.ri;
    assign bus.out_ds    = out_q.ds;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Self-checking bench for decode_queue_stage: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_decode_queue_stage;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
`ifdef DEC_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    decode_queue_stage_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    decode_queue_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    bit          m_valid;
    bit          m_ds;
    bit          m_flag;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    // Class by instruction-set tables; returns {ri, cls[7:0]}.
    function automatic logic [8:0] ref_decode(input logic [31:0] w);
        int    op = int'(w[31:26]);
        int    fn = int'(w[5:0]);
        int    rs = int'(w[25:21]);
        int    rt = int'(w[20:16]);
        string kind = "ri";
        if (op == 0) begin
            if (fn inside {0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}) kind = "alu_r";
            else if (fn inside {8, 9}) kind = "jump";
            else if (fn inside {16, 17, 18, 19, 24, 25, 26, 27}) kind = MDU_ON ? "mdu" : "ri";
        end else if (op == 1) kind = (rt inside {0, 1}) ? "branch" : "ri";
        else if (op inside {2, 3}) kind = "jump";
        else if (op inside {[4:7]}) kind = "branch";
        else if (op inside {[8:15]}) kind = "alu_i";
        else if (op == 16) kind = (rs inside {0, 4, 16}) ? "cp0" : "ri";
        else if (op inside {32, 33, 35, 36, 37}) kind = "load";
        else if (op inside {40, 41, 43}) kind = "store";
        case (kind)
            "alu_r":  return 9'h001;
            "alu_i":  return 9'h002;
            "branch": return 9'h004;
            "load":   return 9'h008;
            "store":  return 9'h010;
            "jump":   return 9'h020;
            "mdu":    return 9'h040;
            "cp0":    return 9'h080;
            default:  return 9'h100;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_valid = 0;
        m_ds    = 0;
        m_flag  = 0;
        m_pc    = '0;
        m_instr = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                              input bit rdy, input bit fl);
        ent_t       e;
        bit         do_push;
        bit         do_pop;
        logic [8:0] d;
        if (fl) begin
            mq.delete();
            m_valid = 0;
            m_flag  = 0;
            return;
        end
        do_push = v && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && (!m_valid || rdy);
        if (do_pop) begin
            e       = mq.pop_front();
            m_valid = 1;
            m_pc    = e.pc;
            m_instr = e.instr;
            m_ds    = m_flag;
            d       = ref_decode(e.instr);
            m_flag  = d[2] | d[5];
        end else if (rdy) begin
            m_valid = 0;
        end
        if (do_push) begin
            e.pc    = pc;
            e.instr = ins;
            mq.push_back(e);
        end
    endtask

    function automatic logic [103:0] exp_vec();
        logic [8:0] d = ref_decode(m_instr);
        return {m_pc, d[7:0], d[8], m_ds, m_instr[25:21], m_instr[20:16], m_instr[15:11],
                m_instr[10:6], m_instr[15:0], m_instr[25:0]};
    endfunction

    // Drive one cycle from a falling edge; returns at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit rdy, input bit fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(posedge clk);
        model_step(v, pc, ins, rdy, fl);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  pool [20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h09, 6'h0C, 6'h0F, 6'h10, 6'h23, 6'h24, 6'h29, 6'h2B, 6'h1F, 6'h3A};
        logic [4:0]  rs_pool [4] = '{5'h00, 5'h04, 5'h10, 5'h08};
        logic [31:0] w = $urandom();
        w[31:26] = pool[$urandom_range(0, 19)];
        if (w[31:26] == 6'h01) w[20:16] = 5'($urandom_range(0, 3));
        if (w[31:26] == 6'h10) w[25:21] = rs_pool[$urandom_range(0, 3)];
        if ($urandom_range(0, 15) == 0) w = '0;
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++;
        if ({bus.out_pc, bus.out_cls, bus.out_ri, bus.out_ds, bus.out_imm, bus.out_tgt, bus.out_rs,
             bus.out_rt, bus.out_rd, bus.out_shamt} !== '0) begin
            n_err++; $display("FAIL reset_data got pc=%h cls=%h ri=%b ds=%b want all zero",
                              bus.out_pc, bus.out_cls, bus.out_ri, bus.out_ds);
        end
    endtask

    task automatic test_addu();
        cycle(1, 32'h3000, 32'h0022_1821, 1, 0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL addu_latency got valid=%b want 0", bus.out_valid); end
        cycle(0, 0, 0, 1, 0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL addu_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_cls !== 8'h01) begin n_err++; $display("FAIL addu_cls got %h want 01", bus.out_cls); end
        n_cmp++;
        if ({bus.out_rs, bus.out_rt, bus.out_rd} !== {5'd1, 5'd2, 5'd3}) begin
            n_err++; $display("FAIL addu_fields got rs=%0d rt=%0d rd=%0d want 1 2 3", bus.out_rs, bus.out_rt, bus.out_rd);
        end
        n_cmp++; if (bus.out_ri !== 1'b0) begin n_err++; $display("FAIL addu_ri got %b want 0", bus.out_ri); end
        n_cmp++; if (bus.out_pc !== 32'h3000) begin n_err++; $display("FAIL addu_pc got %h want 3000", bus.out_pc); end
    endtask

    task automatic test_delay_slot();
        cycle(1, 32'h3100, 32'h1022_0003, 1, 0);
        cycle(1, 32'h3104, 32'h2401_0005, 1, 0);
        n_cmp++;
        if ({bus.out_cls, bus.out_ds} !== {8'h04, 1'b0}) begin
            n_err++; $display("FAIL ds_beq got cls=%h ds=%b want 04 0", bus.out_cls, bus.out_ds);
        end
        cycle(1, 32'h3108, 32'h2402_0007, 1, 0);
        n_cmp++;
        if ({bus.out_cls, bus.out_imm, bus.out_ds} !== {8'h02, 16'd5, 1'b1}) begin
            n_err++; $display("FAIL ds_slot got cls=%h imm=%0d ds=%b want 02 5 1", bus.out_cls, bus.out_imm, bus.out_ds);
        end
        cycle(0, 0, 0, 1, 0);
        n_cmp++;
        if ({bus.out_pc, bus.out_ds} !== {32'h3108, 1'b0}) begin
            n_err++; $display("FAIL ds_after got pc=%h ds=%b want 3108 0", bus.out_pc, bus.out_ds);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 32'h4000 + 32'(4 * i), 32'h2400_0000, 0, 0);
            n_cmp++;
            if (bus.in_ready !== (mq.size() < DEPTH)) begin
                n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, bus.in_ready, mq.size() < DEPTH);
            end
        end
        n_cmp++;
        if ({bus.count, bus.in_ready, bus.out_pc} !== {3'd4, 1'b0, 32'h4000}) begin
            n_err++; $display("FAIL bp_full got count=%0d in_ready=%b pc=%h want 4 0 4000", bus.count, bus.in_ready, bus.out_pc);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) seen.push_back(bus.out_pc);
            cycle(0, 0, 0, 1, 0);
        end
        n_cmp++; if (seen.size() !== 5) begin n_err++; $display("FAIL bp_drain_count got %0d want 5", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            n_cmp++;
            if (seen[i] !== 32'h4000 + 32'(4 * i)) begin
                n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, seen[i], 32'h4000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1, 32'h6000 + 32'(4 * i), 32'h2400_0000, 0, 0);
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL flush_prefill got %0d want 4", bus.count); end
        cycle(1, 32'hDEAD0, 32'h2400_0000, 0, 1);
        n_cmp++;
        if ({bus.count, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL flush_state got count=%0d valid=%b in_ready=%b want 0 0 1",
                              bus.count, bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost[%0d] got valid=%b pc=%h want 0", i, bus.out_valid, bus.out_pc); end
        end
    endtask

    task automatic test_reserved();
        logic [7:0] want_cls;
        logic       want_ri;
        cycle(1, 32'h5000, 32'h7C00_0000, 1, 0);
        cycle(1, 32'h5004, 32'h0022_0018, 1, 0);
        n_cmp++;
        if ({bus.out_ri, bus.out_cls} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL ri_opcode got ri=%b cls=%h want 1 00", bus.out_ri, bus.out_cls);
        end
        cycle(0, 0, 0, 1, 0);
        want_cls = MDU_ON ? 8'h40 : 8'h00;
        want_ri  = !MDU_ON;
        n_cmp++;
        if ({bus.out_ri, bus.out_cls} !== {want_ri, want_cls}) begin
            n_err++; $display("FAIL mult_decode got ri=%b cls=%h want %b %h", bus.out_ri, bus.out_cls, want_ri, want_cls);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom(), rand_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            n_cmp++;
            if ({bus.count, bus.in_ready, bus.out_valid} !== {3'(mq.size()), mq.size() < DEPTH, m_valid}) begin
                n_err++; $display("FAIL rand_ctrl[%0d] got count=%0d rdy=%b valid=%b want %0d %b %b",
                                  i, bus.count, bus.in_ready, bus.out_valid, mq.size(), mq.size() < DEPTH, m_valid);
            end
            if (m_valid) begin
                n_cmp++;
                if ({bus.out_pc, bus.out_cls, bus.out_ri, bus.out_ds, bus.out_rs, bus.out_rt, bus.out_rd,
                     bus.out_shamt, bus.out_imm, bus.out_tgt} !== exp_vec()) begin
                    n_err++; $display("FAIL rand_out[%0d] instr=%h got pc=%h cls=%h ri=%b ds=%b want %h",
                                      i, m_instr, bus.out_pc, bus.out_cls, bus.out_ri, bus.out_ds, exp_vec());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h7000 + 32'(4 * i), 32'h0800_0010, 0, 0);
        n_cmp++;
        if ({bus.count, bus.out_valid} !== {3'd3, 1'b1}) begin
            n_err++; $display("FAIL arst_pre got count=%0d valid=%b want 3 1", bus.count, bus.out_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.count, bus.out_valid, bus.out_ds, bus.in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL arst_now got count=%0d valid=%b ds=%b in_ready=%b want 0 0 0 1",
                              bus.count, bus.out_valid, bus.out_ds, bus.in_ready);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_addu();
        test_delay_slot();
        test_backpressure();
        test_flush();
        test_reserved();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Buffered, handshaked successor to the combinational MIPS instruction decoder.
- Accepts {pc, instr} pairs from fetch into a DEPTH-entry FIFO.
- Decodes the head entry into a class vector plus extracted fields and a reserved-instruction flag, and holds the result in an output register for the execute stage.
- Tracks branch/jump delay slots across dispatched instructions; supports a pipeline flush.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2
PC_W, 32, program-counter width
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  discard all queued and held instructions
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept; = !full
in_pc  in  PC_W  pc of the instruction
in_instr  in  32  raw instruction word
out_valid  out  1  decoded entry held
out_ready  in  1  execute consumes the held entry
out_pc  out  PC_W  pc of the held entry
out_cls  out  8  {cp0, mdu, jump, store, load, branch, alu_i, alu_r}
out_rs, out_rt, out_rd, out_shamt  out  5 each  instruction fields
out_imm  out  16  immediate field
out_tgt  out  26  jump target field
out_ri  out  1  reserved/illegal instruction
out_ds  out  1  entry sits in a delay slot
count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, out_valid=0, out_ds=0, delay-slot flag=0, and all out_* data outputs set to 0.
- Push: occurs when in_valid && in_ready. There is no same-cycle push into a full FIFO, even if a pop occurs in that cycle.
- Pop/load: occurs when the FIFO is non-empty and (!out_valid || out_ready).
  - The head entry is decoded and registered into out_*; out_valid=1.
  - If the FIFO is empty and out_ready=1, out_valid falls to 0.
- Latency: an entry pushed at edge N into an empty FIFO with the output free is visible at out_* after edge N+1.
- Simultaneous push and pop: count is unchanged; the read and write pointers both advance and wrap modulo DEPTH.
- Backpressure: when out_valid && !out_ready, the output register holds and the FIFO fills. in_ready drops once count==DEPTH.
- Flush (synchronous, highest priority over push and pop): at the next edge, count=0, pointers=0, out_valid=0, and delay-slot flag=0. A push in the same cycle as flush is dropped.
- Delay slot: when a loaded entry has cls.branch or cls.jump set, the flag is set. The next loaded entry gets out_ds=flag, and the flag is then updated from that entry's class.
- Decode classes:
  - alu_r: R-type add/addu/sub/subu/shift(v)/logic/slt(u).
  - alu_i: addi/addiu/andi/ori/xori/lui/slti/sltiu.
  - branch: beq/bne/blez/bgtz, plus REGIMM with rt ∈ {BLTZ, BGEZ}.
  - load: lb/lbu/lh/lhu/lw.
  - store: sb/sh/sw.
  - jump: j/jal/jr/jalr.
  - mdu: mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
  - cp0: mfc0/mtc0/eret.
- Reserved instructions: out_ri=1 and out_cls=0 for any of:
  - an unlisted opcode;
  - an R-type with an unlisted funct;
  - REGIMM with another rt;
  - COP0 with another rs.
- Word 0x00000000 (sll nop) is legal alu_r.

Optional Feature:
- Macro: DEC_MDU_EN.
- Defined: mult/multu/div/divu/mfhi/mflo/mthi/mtlo decode to cls.mdu.
- Undefined: those functs decode as reserved (out_ri=1), and cls bit 6 is tied to 0.

Decomposition:
- Opcode, funct, rt and rs encodings stay in the shared public.v include.
- Add CLS_* bit-index defines and CLS_W=8 to public.v.
- One sub-module, instr_class_dec: purely combinational; maps instr to {cls, ri}.
- The FIFO, output register and delay-slot flag live in decode_queue_stage.

Test Plan:
- Push 0x00221821 (addu $3,$1,$2) at pc 0x3000, out_ready=1 → after 2 edges: out_cls=8'h01, rs=1, rt=2, rd=3, out_ri=0, out_pc=0x3000.
- Push 0x10220003 (beq) then 0x24010005 (addiu) → beq out_cls=8'h04 with out_ds=0; addiu out_cls=8'h02, out_imm=5, out_ds=1; a third addiu shows out_ds=0.
- DEPTH=4, out_ready=0, push 6 entries → in_ready=0 once count=4 (one entry held in output); raise out_ready → entries drain in order, with pc order preserved across pointer wrap.
- Queue full and flush=1 together with in_valid=1 → next edge: count=0, out_valid=0, in_ready=1; the flushed-cycle entry never appears.
- Push 0x7C000000 → out_ri=1, out_cls=0. Push 0x00220018 (mult) → out_cls=8'h40 with DEC_MDU_EN defined; out_ri=1 without it.
- Assert reset mid-stream with count=3 → count=0 and out_valid=0 immediately, without waiting for a clk edge.
